// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: serialises whole transactions from two host masters onto the core_selector bus.
// Round-robin by default; define ARB_FIXED_PRIO_EN to give master 0 fixed priority on ties.
module core_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned READ_LATENCY = 2,
  localparam int unsigned DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,

  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_wr,
  output logic                  bus_rd,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  busy
);

  localparam int unsigned CNT_WIDTH = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } xact_t;

  state_t                state_q, state_d;
  xact_t                 xact_q, xact_d;
  xact_t                 req0, req1, sel_xact;
  logic                  grant_q, grant_d;
  logic                  pick;
  logic                  ack_c;
  logic [CNT_WIDTH-1:0]  lat_q, lat_d;
  logic                  bus_wr_q, bus_wr_d;
  logic                  bus_rd_q, bus_rd_d;
  logic                  m0_ack_q, m0_ack_d;
  logic                  m1_ack_q, m1_ack_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_WIDTH-1:0] m1_rdata_q, m1_rdata_d;
  logic                  busy_q, busy_d;

  assign req0     = {m0_we, m0_addr, m0_wdata};
  assign req1     = {m1_we, m1_addr, m1_wdata};
  assign sel_xact = pick ? req1 : req0;

  // Winner selection when leaving IDLE (1 = master 1)
`ifdef ARB_FIXED_PRIO_EN
  assign pick = ~m0_req;
`else
  logic last_grant_q, last_grant_d;
  assign pick = (m0_req && m1_req) ? ~last_grant_q : ~m0_req;
`endif

  // State and registered-output update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      xact_q       <= '0;
      grant_q      <= 1'b0;
      lat_q        <= '0;
      bus_wr_q     <= 1'b0;
      bus_rd_q     <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      busy_q       <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      xact_q       <= xact_d;
      grant_q      <= grant_d;
      lat_q        <= lat_d;
      bus_wr_q     <= bus_wr_d;
      bus_rd_q     <= bus_rd_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      busy_q       <= busy_d;
`ifndef ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Next state and next values of every registered output
  always_comb begin
    state_d      = state_q;
    xact_d       = xact_q;
    grant_d      = grant_q;
    lat_d        = lat_q;
    bus_wr_d     = 1'b0;
    bus_rd_d     = 1'b0;
    ack_c        = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
`ifndef ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant_d      = pick;
          xact_d       = sel_xact;
          bus_wr_d     = sel_xact.we;
          bus_rd_d     = ~sel_xact.we;
          state_d      = ISSUE;
`ifndef ARB_FIXED_PRIO_EN
          last_grant_d = pick;
`endif
        end
      end
      ISSUE: begin
        if (xact_q.we) begin
          ack_c   = 1'b1;
          state_d = DONE;
        end else begin
          lat_d   = CNT_WIDTH'(READ_LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          ack_c   = 1'b1;
          state_d = DONE;
          if (grant_q) m1_rdata_d = bus_rdata;
          else         m0_rdata_d = bus_rdata;
        end else begin
          lat_d = lat_q - CNT_WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Grant is frozen outside IDLE, so the ack can route on the current grant
    m0_ack_d = ack_c & ~grant_q;
    m1_ack_d = ack_c & grant_q;
    busy_d   = (state_d != IDLE);
  end

  assign bus_addr  = xact_q.addr;
  assign bus_wdata = xact_q.wdata;
  assign bus_wr    = bus_wr_q;
  assign bus_rd    = bus_rd_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign busy      = busy_q;

endmodule
